// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache: same-cycle hits and a blocking 8-word line fill
// from a pipelined memory that returns words in issue order.
module icache_ctrl #(
  parameter int NUM_LINES  = 32,
  parameter int LINE_WORDS = 8,
  parameter int DATA_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic [15:0]       cpu_addr,
  input  logic              inv_all,
  output logic [DATA_W-1:0] cpu_inst,
  output logic              cpu_stall,
  output logic              mem_req,
  output logic [15:0]       mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_valid
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int TAG_W = 16 - 1 - OFF_W - IDX_W;
  localparam int CNT_W = OFF_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LINE_WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t state_q, state_d;

  logic [TAG_W-1:0]  addr_tag;
  logic [IDX_W-1:0]  addr_idx;
  logic [OFF_W-1:0]  addr_off;
  logic              unused_addr_lsb;

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [DATA_W-1:0]    data_mem [NUM_LINES*LINE_WORDS];

  logic [TAG_W-1:0]  miss_tag_q;
  logic [IDX_W-1:0]  miss_idx_q;
  logic [CNT_W-1:0]  iss_q;
  logic [CNT_W-1:0]  rcv_q;
  logic              kill_q;

  logic              hit;
  logic              fill_wr;
  logic              fill_last;

  assign addr_tag        = cpu_addr[15 -: TAG_W];
  assign addr_idx        = cpu_addr[OFF_W+1 +: IDX_W];
  assign addr_off        = cpu_addr[1 +: OFF_W];
  assign unused_addr_lsb = cpu_addr[0];

  // Lookup, fill sequencing and next state; hits are only served from IDLE
  always_comb begin
    hit       = 1'b0;
    cpu_inst  = '0;
    cpu_stall = 1'b0;
    mem_req   = 1'b0;
    mem_addr  = '0;
    fill_wr   = 1'b0;
    fill_last = 1'b0;
    state_d   = state_q;

    hit = cpu_req && (state_q == IDLE) && valid_q[addr_idx] &&
          (tag_mem[addr_idx] == addr_tag);
    if (hit) begin
      cpu_inst = data_mem[{addr_idx, addr_off}];
    end
    cpu_stall = (state_q != IDLE) || (cpu_req && !hit);

    mem_req = (state_q == FILL) && (iss_q < CNT_FULL);
    if (mem_req) begin
      mem_addr = {miss_tag_q, miss_idx_q, iss_q[OFF_W-1:0], 1'b0};
    end

    fill_wr   = (state_q == FILL) && mem_valid && (rcv_q < CNT_FULL);
    fill_last = fill_wr && (rcv_q == CNT_LAST);

    case (state_q)
      IDLE:    if (cpu_req && !hit) state_d = FILL;
      FILL:    if (fill_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM, counters, kill flag and line valid bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= '0;
      iss_q   <= '0;
      rcv_q   <= '0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (state_d == FILL) begin
            iss_q <= '0;
            rcv_q <= '0;
          end
        end
        FILL: begin
          if (mem_req) iss_q <= iss_q + 1'b1;
          if (fill_wr) rcv_q <= rcv_q + 1'b1;
          if (inv_all) kill_q <= 1'b1;
        end
        DONE:    kill_q <= 1'b0;
        default: kill_q <= 1'b0;
      endcase
      if (inv_all) valid_q <= '0;
      // An invalidate seen at any point of the fill leaves the new line invalid
      if (fill_last && !kill_q && !inv_all) valid_q[miss_idx_q] <= 1'b1;
    end
  end

  // Data path: miss address latch, tag and instruction storage (never reset)
  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && (state_d == FILL)) begin
      miss_tag_q <= addr_tag;
      miss_idx_q <= addr_idx;
    end
    if (fill_wr) data_mem[{miss_idx_q, rcv_q[OFF_W-1:0]}] <= mem_data;
    if (fill_last) tag_mem[miss_idx_q] <= miss_tag_q;
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl with a pipelined in-order memory model.
module tb_icache_ctrl;

  localparam int MEM_LAT = 4;
  localparam int PIPE    = MEM_LAT - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req;
  logic [15:0] cpu_addr;
  logic        inv_all;
  logic [15:0] cpu_inst;
  logic        cpu_stall;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_valid;

  int checks = 0;
  int errors = 0;

  logic        pv [PIPE];
  logic [15:0] pa [PIPE];

  always #5 clk = ~clk;

  icache_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .inv_all   (inv_all),
    .cpu_inst  (cpu_inst),
    .cpu_stall (cpu_stall),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_valid (mem_valid)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: capture this cycle's request, advance the memory pipe, land #1 after the edge
  task automatic tick();
    logic        rq;
    logic [15:0] ra;
    rq = mem_req;
    ra = mem_addr;
    @(posedge clk);
    #1;
    for (int i = PIPE - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pa[i] = pa[i-1];
    end
    pv[0]     = rq;
    pa[0]     = ra;
    mem_valid = pv[PIPE-1];
    mem_data  = pv[PIPE-1] ? mem_word(pa[PIPE-1]) : 16'h0000;
  endtask

  // Current cycle is the miss cycle 0; runs through DONE and checks the retry in cycle 13
  task automatic miss_fill(input logic [15:0] a, input int inv_at, input int sw_at,
                           input logic [15:0] sw_addr, input bit expect_hit);
    logic [15:0] cur;
    cur      = a;
    cpu_req  = 1'b1;
    cpu_addr = a;
    inv_all  = 1'b0;
    #1;
    chk("miss_stall", 16'(cpu_stall), 16'h1);
    chk("miss_inst", cpu_inst, 16'h0000);
    for (int c = 1; c <= 12; c++) begin
      tick();
      inv_all = (c == inv_at);
      if (c == sw_at) begin
        cpu_addr = sw_addr;
        cur      = sw_addr;
      end
      #1;
      chk("fill_stall", 16'(cpu_stall), 16'h1);
      chk("fill_inst", cpu_inst, 16'h0000);
      if (c <= 8) begin
        chk("fill_req", 16'(mem_req), 16'h1);
        chk("fill_addr", mem_addr, {a[15:4], 4'(2 * (c - 1))});
      end else begin
        chk("fill_no_req", 16'(mem_req), 16'h0);
      end
    end
    tick();
    inv_all = 1'b0;
    #1;
    if (expect_hit) begin
      chk("retry_stall", 16'(cpu_stall), 16'h0);
      chk("retry_inst", cpu_inst, mem_word(cur));
    end else begin
      chk("retry_miss", 16'(cpu_stall), 16'h1);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    cpu_req   = 1'b0;
    cpu_addr  = 16'h0000;
    inv_all   = 1'b0;
    mem_valid = 1'b0;
    mem_data  = 16'h0000;
    for (int i = 0; i < PIPE; i++) begin
      pv[i] = 1'b0;
      pa[i] = 16'h0000;
    end
    #2;

    // Reset state: stall follows cpu_req, no memory traffic
    chk("rst_stall_idle", 16'(cpu_stall), 16'h0);
    chk("rst_mem_req", 16'(mem_req), 16'h0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    cpu_req = 1'b1;
    #1;
    chk("rst_stall_req", 16'(cpu_stall), 16'h1);
    chk("rst_inst", cpu_inst, 16'h0000);
    tick();
    tick();
    rst_n = 1'b1;

    // Test 1: cold miss at 0x0000
    miss_fill(16'h0000, -1, -1, 16'h0000, 1'b1);

    // Test 2: rest of the line hits back to back
    for (int w = 1; w < 8; w++) begin
      tick();
      cpu_addr = 16'(2 * w);
      #1;
      chk("seq_stall", 16'(cpu_stall), 16'h0);
      chk("seq_req", 16'(mem_req), 16'h0);
      chk("seq_inst", cpu_inst, mem_word(16'(2 * w)));
    end

    // Test 3: conflicting tag on index 0 evicts the first line
    tick();
    miss_fill(16'h0200, -1, -1, 16'h0000, 1'b1);
    cpu_addr = 16'h020E;
    #1;
    chk("conflict_inst", cpu_inst, mem_word(16'h020E));
    cpu_addr = 16'h0000;
    #1;
    chk("conflict_evict", 16'(cpu_stall), 16'h1);
    cpu_req = 1'b0;
    #1;
    tick();

    // Test 4: invalidate mid-fill kills the line, refill then works
    miss_fill(16'h0010, 3, -1, 16'h0000, 1'b0);
    miss_fill(16'h0010, -1, -1, 16'h0000, 1'b1);
    cpu_addr = 16'h0200;
    #1;
    chk("inv_cleared_other", 16'(cpu_stall), 16'h1);
    cpu_addr = 16'h0012;
    inv_all  = 1'b1;
    #1;
    chk("inv_hit_stall", 16'(cpu_stall), 16'h0);
    chk("inv_hit_inst", cpu_inst, mem_word(16'h0012));
    tick();
    inv_all = 1'b0;
    #1;
    chk("inv_after_hit", 16'(cpu_stall), 16'h1);
    cpu_req = 1'b0;
    #1;
    tick();

    // Test 5: reset asserted in fill cycle 5, late returns are ignored
    cpu_req  = 1'b1;
    cpu_addr = 16'h0030;
    #1;
    chk("rf_miss", 16'(cpu_stall), 16'h1);
    for (int c = 1; c <= 5; c++) begin
      tick();
      #1;
      chk("rf_addr", mem_addr, 16'h0030 + 16'(2 * (c - 1)));
    end
    rst_n = 1'b0;
    #1;
    chk("rf_rst_stall", 16'(cpu_stall), 16'h1);
    chk("rf_rst_req", 16'(mem_req), 16'h0);
    chk("rf_rst_addr", mem_addr, 16'h0000);
    cpu_req = 1'b0;
    #1;
    chk("rf_rst_noreq", 16'(cpu_stall), 16'h0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("rf_late_req", 16'(mem_req), 16'h0);
      chk("rf_late_stall", 16'(cpu_stall), 16'h0);
      tick();
    end
    miss_fill(16'h0030, -1, -1, 16'h0000, 1'b1);

    // Test 6: fetch address moves during the fill; latched line still completes
    miss_fill(16'h0020, -1, 3, 16'h0100, 1'b0);
    cpu_addr = 16'h0020;
    #1;
    chk("switch_old_stall", 16'(cpu_stall), 16'h0);
    chk("switch_old_inst", cpu_inst, mem_word(16'h0020));
    cpu_addr = 16'h002E;
    #1;
    chk("switch_last_inst", cpu_inst, mem_word(16'h002E));
    cpu_req = 1'b0;
    #1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
